mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: data word width.
REQ-002 The block SHALL have parameter RAM_ADDR_BITS, default 10: word address width.
REQ-003 The block SHALL have parameter MAX_WAIT, default 4: cycles the VGA requester may lose arbitration before it receives forced priority.
REQ-004 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 The block SHALL have ports cpu_req/cpu_we, input, 1 each: CPU access request, held until cpu_ack; we=1 selects write.
REQ-007 The block SHALL have ports cpu_adr, input, RAM_ADDR_BITS, and cpu_wdata, input, WIDTH: CPU address and write data.
REQ-008 The block SHALL have ports cpu_ack, output, 1, cpu_rdata, output, WIDTH, and cpu_rvalid, output, 1: CPU grant pulse, read data, and one-cycle read-valid strobe.
REQ-009 The block SHALL have ports vga_req, input, 1, and vga_adr, input, RAM_ADDR_BITS: VGA read-only request, held until vga_ack.
REQ-010 The block SHALL have ports vga_ack, output, 1, vga_rdata, output, WIDTH, and vga_rvalid, output, 1: VGA grant pulse, read data, and read-valid strobe.
REQ-011 The block SHALL have ports mem_en, mem_write, mem_read, output, 1 each: registered strobes to the shared memory port.
REQ-012 The block SHALL have ports mem_adr, output, RAM_ADDR_BITS, and mem_wdata, output, WIDTH: registered memory address and write data.
REQ-013 The block SHALL have port mem_rdata, input, WIDTH: memory read data, valid on the cycle after the memory samples mem_read.
REQ-014 The block SHALL have port wr_blocked, output, 1: pulse indicating a suppressed CPU write (only with the REQ-028 macro; otherwise tied 0).

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, RETURN.
- IDLE: arbitrate
- ISSUE: strobes valid for one cycle
- RETURN: capture mem_rdata
REQ-016 In IDLE with any request, the FSM SHALL latch the winner, address, data and we, then enter ISSUE at the next edge.
REQ-017 In ISSUE, the block SHALL drive mem_en=1, mem_adr/mem_wdata latched, and mem_write=we or mem_read=!we. The winner's ack SHALL be high for exactly this cycle.
REQ-018 From ISSUE, a write SHALL return to IDLE and a read SHALL go to RETURN. In RETURN, the block SHALL register mem_rdata into the winner's rdata, pulse its rvalid for one cycle at the next edge, and return to IDLE.
REQ-019 Latency SHALL be as follows.
- Read: request sampled at edge k; ack in cycle k..k+1; rvalid high after edge k+2.
- Write: ack in cycle k..k+1; the write completes at edge k+1.
REQ-020 Priority SHALL be as follows.
- CPU wins a simultaneous request.
- Exception: when vga_wait == MAX_WAIT, VGA wins.
REQ-021 vga_wait SHALL increment, saturating at MAX_WAIT, on each IDLE arbitration where vga_req=1 and the CPU wins. It SHALL clear to 0 when VGA is granted or vga_req=0 in IDLE.
REQ-022 Request inputs SHALL be ignored outside IDLE. A requester that drops req before ack SHALL not be granted.
REQ-023 rdata outputs SHALL hold their last captured value until the next rvalid for that requester.
REQ-024 Outside ISSUE, mem_en, mem_write and mem_read SHALL be 0.

Reset
REQ-025 On rst=1 at an edge, the block SHALL do the following.
- state=IDLE; vga_wait=0.
- All ack, rvalid, mem strobes and wr_blocked = 0; mem_adr, mem_wdata, cpu_rdata, vga_rdata = 0.
REQ-026 Reset during ISSUE or RETURN SHALL abort the access: no rvalid pulse. A write whose ISSUE cycle coincides with the reset edge SHALL not be committed, because the strobes clear at that edge.
REQ-027 The first arbitration after reset release SHALL occur at the first edge with rst=0.

Configuration
REQ-028 With MEM_ARB_IO_PROTECT_EN defined, a CPU write to an address in 529..539 (hardware-owned I/O words) SHALL be granted and acked but issued with mem_write=0 and mem_en=0, and wr_blocked SHALL pulse with ack. Without the macro, all writes SHALL pass and wr_blocked SHALL be constant 0.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the following.
- State enum
- Owner enum (OWN_CPU, OWN_VGA)
- Constants IO_LO=529 and IO_HI=539
REQ-030 The saturating starvation counter SHALL be sub-module mem_arb_starve_ctr (inputs inc, clr; output at_max). The rest SHALL be flat.

Verification
REQ-031 The bench SHALL cover a CPU read: ram[12]=16'hBEEF, cpu_req with adr=12 -> cpu_ack 1 cycle, cpu_rvalid 2 cycles later with cpu_rdata=16'hBEEF.
REQ-032 The bench SHALL cover a CPU write: adr=40, wdata=16'h1234, then a read of 40 -> 16'h1234. mem_write SHALL be high exactly 1 cycle.
REQ-033 The bench SHALL cover simultaneous requests with both held continuously: CPU granted 4 times, then VGA granted on the 5th arbitration (MAX_WAIT=4), with vga_wait returning to 0.
REQ-034 The bench SHALL cover reset mid-read: rst asserted in RETURN -> no rvalid; the next cycle shows IDLE with all outputs 0.
REQ-035 The bench SHALL cover the protected-write case with the macro defined: CPU write 16'hFFFF to adr 530 -> ack and wr_blocked pulse, mem_en stays 0, and ram[530] is unchanged. Without the macro, the write commits.
REQ-036 The bench SHALL cover a request dropped early: vga_req pulsed for 1 cycle while the FSM is in ISSUE for the CPU -> no vga_ack.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/VGA memory-port arbiter.
// The I/O window bounds are only consulted when MEM_ARB_IO_PROTECT_EN is defined.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RETURN
    } state_e;

    typedef enum logic {
        OWN_CPU,
        OWN_VGA
    } owner_e;

    localparam int unsigned IO_LO = 529;
    localparam int unsigned IO_HI = 539;

    function automatic logic is_io_addr(input int unsigned adr);
        return (adr >= IO_LO) && (adr <= IO_HI);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/grant/data bundle between the CPU, the VGA reader, the shared memory
// port and the arbiter. The arbiter takes the slave view, its environment the master view.
interface mem_port_arbiter_if #(
    parameter int WIDTH         = 16,
    parameter int RAM_ADDR_BITS = 10
);
    logic                     cpu_req;
    logic                     cpu_we;
    logic [RAM_ADDR_BITS-1:0] cpu_adr;
    logic [WIDTH-1:0]         cpu_wdata;
    logic                     cpu_ack;
    logic [WIDTH-1:0]         cpu_rdata;
    logic                     cpu_rvalid;

    logic                     vga_req;
    logic [RAM_ADDR_BITS-1:0] vga_adr;
    logic                     vga_ack;
    logic [WIDTH-1:0]         vga_rdata;
    logic                     vga_rvalid;

    logic                     mem_en;
    logic                     mem_write;
    logic                     mem_read;
    logic [RAM_ADDR_BITS-1:0] mem_adr;
    logic [WIDTH-1:0]         mem_wdata;
    logic [WIDTH-1:0]         mem_rdata;
    logic                     wr_blocked;

    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wdata, vga_req, vga_adr, mem_rdata,
        output cpu_ack, cpu_rdata, cpu_rvalid, vga_ack, vga_rdata, vga_rvalid,
        output mem_en, mem_write, mem_read, mem_adr, mem_wdata, wr_blocked
    );

    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wdata, vga_req, vga_adr, mem_rdata,
        input  cpu_ack, cpu_rdata, cpu_rvalid, vga_ack, vga_rdata, vga_rvalid,
        input  mem_en, mem_write, mem_read, mem_adr, mem_wdata, wr_blocked
    );
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of arbitrations the VGA requester has lost; at_max grants it
// forced priority on the next arbitration.
module mem_arb_starve_ctr #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_CNT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (CPU read/write, VGA read-only) for one synchronous memory port.
// Optional MEM_ARB_IO_PROTECT_EN suppresses CPU writes to the hardware-owned I/O words.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int RAM_ADDR_BITS = 10,
    parameter int MAX_WAIT      = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  io
);
    state_e                   state_q, state_d;
    owner_e                   owner_q, owner_d;
    logic [RAM_ADDR_BITS-1:0] mem_adr_q, mem_adr_d;
    logic [WIDTH-1:0]         mem_wdata_q, mem_wdata_d;
    logic                     mem_en_q, mem_en_d;
    logic                     mem_write_q, mem_write_d;
    logic                     mem_read_q, mem_read_d;
    logic                     cpu_ack_q, cpu_ack_d;
    logic                     vga_ack_q, vga_ack_d;
    logic                     cpu_rvalid_q, cpu_rvalid_d;
    logic                     vga_rvalid_q, vga_rvalid_d;
    logic [WIDTH-1:0]         cpu_rdata_q, cpu_rdata_d;
    logic [WIDTH-1:0]         vga_rdata_q, vga_rdata_d;

    logic any_req, vga_win, blk_hit, at_max, in_idle;

    assign in_idle = (state_q == IDLE);
    assign any_req = io.cpu_req | io.vga_req;
    assign vga_win = io.vga_req & (~io.cpu_req | at_max);

    mem_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (in_idle & io.vga_req & ~vga_win),
        .clr    (in_idle & (~io.vga_req | vga_win)),
        .at_max (at_max)
    );

`ifdef MEM_ARB_IO_PROTECT_EN
    logic wr_blocked_q;

    assign blk_hit = io.cpu_req & ~vga_win & io.cpu_we & is_io_addr(32'(io.cpu_adr));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_blocked_q <= 1'b0;
        end else begin
            wr_blocked_q <= in_idle & blk_hit;
        end
    end

    assign io.wr_blocked = wr_blocked_q;
`else
    assign blk_hit       = 1'b0;
    assign io.wr_blocked = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        mem_adr_d    = mem_adr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_en_d     = 1'b0;
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        cpu_ack_d    = 1'b0;
        vga_ack_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        vga_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        vga_rdata_d  = vga_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ISSUE;
                    if (vga_win) begin
                        owner_d    = OWN_VGA;
                        mem_adr_d  = io.vga_adr;
                        mem_en_d   = 1'b1;
                        mem_read_d = 1'b1;
                        vga_ack_d  = 1'b1;
                    end else begin
                        owner_d     = OWN_CPU;
                        mem_adr_d   = io.cpu_adr;
                        mem_wdata_d = io.cpu_wdata;
                        mem_en_d    = ~blk_hit;
                        mem_write_d = io.cpu_we & ~blk_hit;
                        mem_read_d  = ~io.cpu_we;
                        cpu_ack_d   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // Only reads wait for data; writes (blocked or not) are done.
                state_d = mem_read_q ? RETURN : IDLE;
            end
            RETURN: begin
                state_d = IDLE;
                if (owner_q == OWN_CPU) begin
                    cpu_rdata_d  = io.mem_rdata;
                    cpu_rvalid_d = 1'b1;
                end else begin
                    vga_rdata_d  = io.mem_rdata;
                    vga_rvalid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CPU;
            mem_adr_q    <= '0;
            mem_wdata_q  <= '0;
            mem_en_q     <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            cpu_ack_q    <= 1'b0;
            vga_ack_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            vga_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            vga_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            mem_adr_q    <= mem_adr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_en_q     <= mem_en_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            cpu_ack_q    <= cpu_ack_d;
            vga_ack_q    <= vga_ack_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            vga_rvalid_q <= vga_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            vga_rdata_q  <= vga_rdata_d;
        end
    end

    assign io.mem_en     = mem_en_q;
    assign io.mem_write  = mem_write_q;
    assign io.mem_read   = mem_read_q;
    assign io.mem_adr    = mem_adr_q;
    assign io.mem_wdata  = mem_wdata_q;
    assign io.cpu_ack    = cpu_ack_q;
    assign io.vga_ack    = vga_ack_q;
    assign io.cpu_rvalid = cpu_rvalid_q;
    assign io.vga_rvalid = vga_rvalid_q;
    assign io.cpu_rdata  = cpu_rdata_q;
    assign io.vga_rdata  = vga_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: transaction-level model of the arbiter plus a RAM behind
// the memory port; directed scenarios first, then randomized traffic with resets.
module tb_mem_port_arbiter;
    localparam int W  = 16;
    localparam int AB = 10;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.WIDTH(W), .RAM_ADDR_BITS(AB)) bus ();

    mem_port_arbiter #(.WIDTH(W), .RAM_ADDR_BITS(AB), .MAX_WAIT(MW)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] ram    [1<<AB];
    logic [W-1:0] shadow [1<<AB];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory behind the port: writes land at the issuing edge, reads return one cycle later.
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_write && !rst) ram[bus.mem_adr] <= bus.mem_wdata;
        if (bus.mem_en && bus.mem_read) bus.mem_rdata <= ram[bus.mem_adr];
    end

    function automatic bit protected_adr(input logic [AB-1:0] adr);
`ifdef MEM_ARB_IO_PROTECT_EN
        return (adr >= 10'd529) && (adr <= 10'd539);
`else
        return 1'b0;
`endif
    endfunction

    // Model: one outstanding access described by its grant edge; everything else
    // follows from fixed latencies (write busy 2 edges, read busy 3 edges).
    int           n = 0;
    int           next_arb = 0;
    int           vwait = 0;
    bit           acc_valid = 1'b0;
    int           acc_g = 0;
    bit           acc_vga, acc_we, acc_blk;
    bit           cr, vr;
    logic [AB-1:0] acc_adr;
    logic [W-1:0]  acc_wdata;
    logic [W-1:0]  exp_cpu_rdata = '0;
    logic [W-1:0]  exp_vga_rdata = '0;

    always @(posedge clk) begin
        n++;
        if (!rst && acc_valid) begin
            if (acc_we && !acc_blk && n == acc_g + 1) shadow[acc_adr] = acc_wdata;
            if (!acc_we && n == acc_g + 2) begin
                if (acc_vga) exp_vga_rdata = shadow[acc_adr];
                else         exp_cpu_rdata = shadow[acc_adr];
            end
        end
        if (rst) begin
            acc_valid     = 1'b0;
            vwait         = 0;
            next_arb      = n + 1;
            exp_cpu_rdata = '0;
            exp_vga_rdata = '0;
        end else if (n >= next_arb) begin
            cr = bus.cpu_req;
            vr = bus.vga_req;
            if (!cr && !vr) begin
                vwait    = 0;
                next_arb = n + 1;
            end else begin
                acc_valid = 1'b1;
                acc_g     = n;
                acc_vga   = vr && (!cr || vwait == MW);
                vwait     = (vr && !acc_vga) ? ((vwait < MW) ? vwait + 1 : MW) : 0;
                if (acc_vga) begin
                    acc_we  = 1'b0;
                    acc_blk = 1'b0;
                    acc_adr = bus.vga_adr;
                end else begin
                    acc_we    = bus.cpu_we;
                    acc_adr   = bus.cpu_adr;
                    acc_wdata = bus.cpu_wdata;
                    acc_blk   = acc_we && protected_adr(acc_adr);
                end
                next_arb = n + (acc_we ? 2 : 3);
            end
        end
    end

    logic [15:0] glog = '0;
    int          wr_cycles = 0;
    bit          iss, rv;

    always @(negedge clk) begin
        if (n > 0) begin
            iss = acc_valid && acc_g == n;
            rv  = acc_valid && !acc_we && n == acc_g + 2;
            check("cpu_ack",    32'(bus.cpu_ack),    32'(iss && !acc_vga));
            check("vga_ack",    32'(bus.vga_ack),    32'(iss && acc_vga));
            check("mem_en",     32'(bus.mem_en),     32'(iss && !acc_blk));
            check("mem_write",  32'(bus.mem_write),  32'(iss && !acc_blk && acc_we));
            check("mem_read",   32'(bus.mem_read),   32'(iss && !acc_we));
            check("wr_blocked", 32'(bus.wr_blocked), 32'(iss && acc_blk));
            check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(rv && !acc_vga));
            check("vga_rvalid", 32'(bus.vga_rvalid), 32'(rv && acc_vga));
            check("cpu_rdata",  32'(bus.cpu_rdata),  32'(exp_cpu_rdata));
            check("vga_rdata",  32'(bus.vga_rdata),  32'(exp_vga_rdata));
            if (iss && !acc_blk) check("mem_adr", 32'(bus.mem_adr), 32'(acc_adr));
            if (iss && acc_we && !acc_blk) check("mem_wdata", 32'(bus.mem_wdata), 32'(acc_wdata));
            if (bus.cpu_ack) glog = {glog[14:0], 1'b0};
            if (bus.vga_ack) glog = {glog[14:0], 1'b1};
            if (bus.mem_write) wr_cycles++;
        end
    end

    task automatic cpu_access(input bit we, input logic [AB-1:0] adr, input logic [W-1:0] wd);
        bit ok;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_adr   = adr;
        bus.cpu_wdata = wd;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.cpu_ack) begin
                ok = 1'b1;
                break;
            end
        end
        bus.cpu_req = 1'b0;
        check("cpu_ack_seen", 32'(ok), 32'd1);
    endtask

    function automatic logic [AB-1:0] rand_adr();
        if ($urandom_range(0, 1) == 0) return AB'($urandom_range(525, 545));
        return AB'($urandom_range(0, (1 << AB) - 1));
    endfunction

    int w0, vcnt;

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_adr = '0; bus.cpu_wdata = '0;
        bus.vga_req = 1'b0; bus.vga_adr = '0;
        for (int i = 0; i < (1 << AB); i++) begin
            ram[i]    = W'(i * 7 + 3);
            shadow[i] = W'(i * 7 + 3);
        end
        ram[12]  = 16'hBEEF; shadow[12]  = 16'hBEEF;
        ram[530] = 16'h5A5A; shadow[530] = 16'h5A5A;

        repeat (3) @(negedge clk);
        check("rst_cpu_ack",   32'(bus.cpu_ack),   32'd0);
        check("rst_mem_en",    32'(bus.mem_en),    32'd0);
        check("rst_mem_adr",   32'(bus.mem_adr),   32'd0);
        check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        rst = 1'b0;

        // CPU read of a preloaded word
        cpu_access(1'b0, 10'd12, '0);
        @(negedge clk);
        check("rd12_rvalid_early", 32'(bus.cpu_rvalid), 32'd0);
        @(negedge clk);
        check("rd12_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        check("rd12_data",   32'(bus.cpu_rdata),  32'h0000BEEF);

        // CPU write then read-back; exactly one mem_write cycle
        @(negedge clk); #1;
        w0 = wr_cycles;
        cpu_access(1'b1, 10'd40, 16'h1234);
        repeat (2) @(negedge clk);
        #1;
        check("wr40_strobe_cycles", 32'(wr_cycles - w0), 32'd1);
        cpu_access(1'b0, 10'd40, '0);
        repeat (2) @(negedge clk);
        check("rd40_data", 32'(bus.cpu_rdata), 32'h00001234);

        // Both held: CPU x4, VGA, CPU x4, VGA
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 10'd100;
        bus.vga_req = 1'b1; bus.vga_adr = 10'd200;
        vcnt = 0;
        for (int i = 0; i < 80 && vcnt < 2; i++) begin
            @(negedge clk);
            if (bus.vga_ack) vcnt++;
        end
        bus.cpu_req = 1'b0; bus.vga_req = 1'b0;
        check("starve_vga_grants", 32'(vcnt), 32'd2);
        @(negedge clk); #1;
        check("starve_grant_order", 32'(glog[9:0]), 32'b0000100001);

        // Reset while waiting for read data aborts the read
        repeat (3) @(negedge clk);
        cpu_access(1'b0, 10'd77, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_rvalid",  32'(bus.cpu_rvalid), 32'd0);
        check("rstmid_ack",     32'(bus.cpu_ack),    32'd0);
        check("rstmid_mem_en",  32'(bus.mem_en),     32'd0);
        check("rstmid_mem_adr", 32'(bus.mem_adr),    32'd0);
        check("rstmid_rdata",   32'(bus.cpu_rdata),  32'd0);
        rst = 1'b0;

        // Write into the I/O window
        @(negedge clk);
        cpu_access(1'b1, 10'd530, 16'hFFFF);
`ifdef MEM_ARB_IO_PROTECT_EN
        check("io_wr_blocked", 32'(bus.wr_blocked), 32'd1);
        check("io_mem_en",     32'(bus.mem_en),     32'd0);
        repeat (2) @(negedge clk);
        check("io_ram530", 32'(ram[530]), 32'h00005A5A);
`else
        check("io_wr_blocked", 32'(bus.wr_blocked), 32'd0);
        check("io_mem_en",     32'(bus.mem_en),     32'd1);
        repeat (2) @(negedge clk);
        check("io_ram530", 32'(ram[530]), 32'h0000FFFF);
`endif

        // VGA request pulsed only while the CPU access is in ISSUE
        @(negedge clk);
        cpu_access(1'b0, 10'd300, '0);
        bus.vga_req = 1'b1; bus.vga_adr = 10'd5;
        @(negedge clk);
        bus.vga_req = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.vga_ack) vcnt++;
        end
        check("early_drop_vga_ack", 32'(vcnt), 32'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 99) == 0) rst = 1'b1;
            if (bus.cpu_req && bus.cpu_ack) bus.cpu_req = 1'b0;
            else if (bus.cpu_req && $urandom_range(0, 15) == 0) bus.cpu_req = 1'b0;
            else if (!bus.cpu_req && $urandom_range(0, 2) == 0) begin
                bus.cpu_req   = 1'b1;
                bus.cpu_we    = 1'($urandom_range(0, 1));
                bus.cpu_adr   = rand_adr();
                bus.cpu_wdata = W'($urandom);
            end
            if (bus.vga_req && bus.vga_ack) bus.vga_req = 1'b0;
            else if (bus.vga_req && $urandom_range(0, 15) == 0) bus.vga_req = 1'b0;
            else if (!bus.vga_req && $urandom_range(0, 2) == 0) begin
                bus.vga_req = 1'b1;
                bus.vga_adr = rand_adr();
            end
        end
        bus.cpu_req = 1'b0; bus.vga_req = 1'b0; rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
